// File: rtl/msg_us_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : msg_us_frame_arbiter
//  Description : Frame-granular round-robin arbiter sharing one upstream FIFO
//                write port among NUM_SRC frame sources. A grant is held from
//                the first beat to the last beat of a frame. A watchdog
//                releases the port if the granted source stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module msg_us_frame_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 4096
) (
    input  logic                      sys_clk_i,
    input  logic                      rst_i,
    input  logic [NUM_SRC-1:0]        src_req_i,
    output logic [NUM_SRC-1:0]        src_grant_o,
    input  logic [NUM_SRC-1:0]        src_valid_i,
    input  logic [NUM_SRC-1:0]        src_last_i,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
    input  logic                      us_prog_full_i,
    output logic                      us_wr_clk_o,
    output logic                      us_wr_en_o,
    output logic [DATA_W-1:0]         us_wr_dout_o,
    output logic [15:0]               frame_cnt_o,
    output logic                      timeout_o
);

    localparam int c_IDX_W  = $clog2(NUM_SRC);
    localparam int c_WDOG_W = $clog2(TIMEOUT) + 1;
    localparam logic [c_WDOG_W-1:0] c_WDOG_MAX = c_WDOG_W'(TIMEOUT - 1);
    localparam logic [NUM_SRC-1:0]  c_ONE      = {{(NUM_SRC-1){1'b0}}, 1'b1};
    localparam logic [c_IDX_W-1:0]  c_RR_INIT  = c_IDX_W'(NUM_SRC - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [NUM_SRC-1:0]    r_grant, w_grant_nxt;
    logic [c_IDX_W-1:0]    r_gidx, w_gidx_nxt;
    logic [c_IDX_W-1:0]    r_rr_ptr, w_rr_nxt;
    logic [c_WDOG_W-1:0]   r_wdog, w_wdog_nxt;
    logic [15:0]           r_frame_cnt, w_cnt_nxt;
    logic                  r_timeout, w_timeout_nxt;
    logic                  r_wr_en;
    logic [DATA_W-1:0]     r_wr_dout;

    logic                  w_pick_found;
    logic [c_IDX_W-1:0]    w_pick_idx;
    logic [c_IDX_W-1:0]    w_cand;
    logic                  w_g_valid;
    logic                  w_g_last;
    logic [DATA_W-1:0]     w_g_data;

    // Grant is zero outside S_XFER, so masking with it qualifies beats.
    assign w_g_valid = |(r_grant & src_valid_i);
    assign w_g_last  = |(r_grant & src_valid_i & src_last_i);
    assign w_g_data  = src_data_i[int'(r_gidx) * DATA_W +: DATA_W];

    // Round-robin search: first requester after the last served index.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_cand       = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_cand = c_IDX_W'((int'(r_rr_ptr) + k) % NUM_SRC);
            if (!w_pick_found && src_req_i[w_cand]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_cand;
            end
        end
    end

    // Next-state logic: grant on request, hold until last beat or watchdog.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_gidx_nxt    = r_gidx;
        w_rr_nxt      = r_rr_ptr;
        w_wdog_nxt    = r_wdog;
        w_cnt_nxt     = r_frame_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant_nxt = '0;
                w_wdog_nxt  = '0;
                if (w_pick_found && !us_prog_full_i) begin
                    w_state_nxt = S_XFER;
                    w_grant_nxt = c_ONE << w_pick_idx;
                    w_gidx_nxt  = w_pick_idx;
                end
            end
            S_XFER: begin
                if (w_g_last) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_rr_nxt    = r_gidx;
                    w_cnt_nxt   = r_frame_cnt + 16'd1;
                    w_wdog_nxt  = '0;
                end else if (w_g_valid) begin
                    w_wdog_nxt = '0;
                end else if (r_wdog == c_WDOG_MAX) begin
                    w_state_nxt   = S_IDLE;
                    w_grant_nxt   = '0;
                    w_rr_nxt      = r_gidx;
                    w_timeout_nxt = 1'b1;
                    w_wdog_nxt    = '0;
                end else begin
                    w_wdog_nxt = r_wdog + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_wdog_nxt  = '0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_gidx      <= '0;
            r_rr_ptr    <= c_RR_INIT;
            r_wdog      <= '0;
            r_frame_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_gidx      <= w_gidx_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_wdog      <= w_wdog_nxt;
            r_frame_cnt <= w_cnt_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    // Write datapath: one-cycle registered copy of the granted beat; data holds when idle.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_en   <= 1'b0;
            r_wr_dout <= '0;
        end else begin
            r_wr_en <= w_g_valid;
            if (w_g_valid) begin
                r_wr_dout <= w_g_data;
            end
        end
    end

    assign src_grant_o  = r_grant;
    assign us_wr_clk_o  = sys_clk_i;
    assign us_wr_en_o   = r_wr_en;
    assign us_wr_dout_o = r_wr_dout;
    assign frame_cnt_o  = r_frame_cnt;
    assign timeout_o    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_msg_us_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msg_us_frame_arbiter
//  Description : Directed, table-driven self-checking bench for
//                msg_us_frame_arbiter (NUM_SRC=4, DATA_W=128, TIMEOUT=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msg_us_frame_arbiter;

    localparam int NUM_SRC = 4;
    localparam int DATA_W  = 128;
    localparam int TIMEOUT = 16;

    logic                      clk;
    logic                      rst;
    logic [NUM_SRC-1:0]        src_req;
    logic [NUM_SRC-1:0]        src_grant;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_last;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic                      prog_full;
    logic                      wr_clk;
    logic                      wr_en;
    logic [DATA_W-1:0]         wr_dout;
    logic [15:0]               frame_cnt;
    logic                      timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_grant;
        int         nbeats;
    } vec_t;

    vec_t vecs [12];

    msg_us_frame_arbiter #(
        .NUM_SRC (NUM_SRC),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .sys_clk_i      (clk),
        .rst_i          (rst),
        .src_req_i      (src_req),
        .src_grant_o    (src_grant),
        .src_valid_i    (src_valid),
        .src_last_i     (src_last),
        .src_data_i     (src_data),
        .us_prog_full_i (prog_full),
        .us_wr_clk_o    (wr_clk),
        .us_wr_en_o     (wr_en),
        .us_wr_dout_o   (wr_dout),
        .frame_cnt_o    (frame_cnt),
        .timeout_o      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mkdata(input int tag, input int src, input int b);
        return {64'hC0DE_5A5A_0000_0000, 32'(tag), 16'(src), 16'(b)};
    endfunction

    function automatic int idx_of(input logic [3:0] oh);
        int r = 0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = i;
        return r;
    endfunction

    // Present one beat from a source for one edge and check the registered write.
    task automatic beat(input int src, input logic [127:0] d, input logic last);
        src_valid[src] = 1'b1;
        src_last[src]  = last;
        src_data[src*DATA_W +: DATA_W] = d;
        step();
        check("beat_wr_en", 128'(wr_en), 128'(1));
        check("beat_wr_dout", wr_dout, d);
        src_valid[src] = 1'b0;
        src_last[src]  = 1'b0;
    endtask

    int          exp_cnt;
    int          g;
    logic [127:0] d;

    initial begin
        rst       = 1'b1;
        src_req   = '0;
        src_valid = '0;
        src_last  = '0;
        src_data  = '0;
        prog_full = 1'b0;
        exp_cnt   = 0;

        // Arbitration table: rr pointer starts at 3 so source 0 wins first.
        vecs[0]  = '{4'b1111, 4'b0001, 2};
        vecs[1]  = '{4'b1111, 4'b0010, 2};
        vecs[2]  = '{4'b1111, 4'b0100, 2};
        vecs[3]  = '{4'b1111, 4'b1000, 2};
        vecs[4]  = '{4'b1111, 4'b0001, 2};
        vecs[5]  = '{4'b1111, 4'b0010, 2};
        vecs[6]  = '{4'b1111, 4'b0100, 2};
        vecs[7]  = '{4'b1111, 4'b1000, 2};
        vecs[8]  = '{4'b0001, 4'b0001, 1};
        vecs[9]  = '{4'b0001, 4'b0001, 3};
        vecs[10] = '{4'b1001, 4'b1000, 1};
        vecs[11] = '{4'b0110, 4'b0010, 2};

        #1;
        check("rst_grant", 128'(src_grant), 128'(0));
        check("rst_wr_en", 128'(wr_en), 128'(0));
        check("rst_dout", wr_dout, 128'(0));
        check("rst_cnt", 128'(frame_cnt), 128'(0));
        check("rst_timeout", 128'(timeout), 128'(0));
        step();
        step();
        rst = 1'b0;

        // Table-driven round-robin / fairness sequence.
        for (int i = 0; i < 12; i++) begin
            src_req = vecs[i].req;
            step();
            check("rr_grant", 128'(src_grant), 128'(vecs[i].exp_grant));
            g = idx_of(vecs[i].exp_grant);
            for (int b = 0; b < vecs[i].nbeats; b++)
                beat(g, mkdata(i, g, b), (b == vecs[i].nbeats - 1));
            check("rr_release", 128'(src_grant), 128'(0));
            exp_cnt++;
            check("rr_cnt", 128'(frame_cnt), 128'(exp_cnt));
        end
        src_req = '0;
        step();
        check("idle_wr_en", 128'(wr_en), 128'(0));
        // rr pointer now 1

        // Single source 4-beat frame from source 1 (search 2,3,0,1).
        src_req = 4'b0010;
        step();
        check("t2_grant", 128'(src_grant), 128'(4'b0010));
        src_req = '0;
        for (int b = 0; b < 4; b++) beat(1, mkdata(100, 1, b), (b == 3));
        exp_cnt++;
        check("t2_cnt", 128'(frame_cnt), 128'(exp_cnt));
        step();
        check("t2_wr_en_off", 128'(wr_en), 128'(0));
        check("t2_dout_hold", wr_dout, mkdata(100, 1, 3));

        // Backpressure: no grant while prog_full, grant right after release.
        prog_full = 1'b1;
        src_req   = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_no_grant", 128'(src_grant), 128'(0));
        end
        prog_full = 1'b0;
        step();
        check("t4_grant", 128'(src_grant), 128'(4'b0001));
        src_req = '0;
        beat(0, mkdata(200, 0, 0), 1'b0);
        prog_full = 1'b1;
        beat(0, mkdata(200, 0, 1), 1'b1);
        exp_cnt++;
        check("t4_cnt", 128'(frame_cnt), 128'(exp_cnt));
        check("t4_release", 128'(src_grant), 128'(0));
        prog_full = 1'b0;
        // rr pointer now 0

        // Watchdog: src2 sends one beat then stalls; src3 waits.
        src_req = 4'b1100;
        step();
        check("t5_grant", 128'(src_grant), 128'(4'b0100));
        src_req = 4'b1000;
        beat(2, mkdata(300, 2, 0), 1'b0);
        for (int k = 1; k <= 17; k++) begin
            step();
            if (k == 1)  check("t5_wr_idle", 128'(wr_en), 128'(0));
            if (k == 15) check("t5_pre_to", 128'(timeout), 128'(0));
            if (k == 15) check("t5_pre_grant", 128'(src_grant), 128'(4'b0100));
            if (k == 16) check("t5_timeout", 128'(timeout), 128'(1));
            if (k == 16) check("t5_to_grant", 128'(src_grant), 128'(0));
            if (k == 16) check("t5_to_cnt", 128'(frame_cnt), 128'(exp_cnt));
            if (k == 17) check("t5_to_pulse", 128'(timeout), 128'(0));
            if (k == 17) check("t5_next_grant", 128'(src_grant), 128'(4'b1000));
        end
        src_req = '0;
        beat(3, mkdata(301, 3, 0), 1'b1);
        exp_cnt++;
        check("t5_cnt", 128'(frame_cnt), 128'(exp_cnt));
        // rr pointer now 3

        // Spurious beats from a non-granted source are dropped.
        src_req = 4'b0100;
        step();
        check("t6_grant", 128'(src_grant), 128'(4'b0100));
        src_req = '0;
        src_valid[0] = 1'b1;
        src_data[0 +: DATA_W] = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
        step();
        check("t6_no_wr", 128'(wr_en), 128'(0));
        beat(2, mkdata(400, 2, 0), 1'b0);
        beat(2, mkdata(400, 2, 1), 1'b1);
        src_valid[0] = 1'b0;
        exp_cnt++;
        check("t6_cnt", 128'(frame_cnt), 128'(exp_cnt));
        step();
        check("t6_wr_off", 128'(wr_en), 128'(0));
        // rr pointer now 2

        // Asynchronous reset in the middle of a frame.
        src_req = 4'b0001;
        step();
        check("t1_grant", 128'(src_grant), 128'(4'b0001));
        beat(0, mkdata(500, 0, 0), 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("t1_grant_rst", 128'(src_grant), 128'(0));
        check("t1_wr_en_rst", 128'(wr_en), 128'(0));
        check("t1_dout_rst", wr_dout, 128'(0));
        check("t1_cnt_rst", 128'(frame_cnt), 128'(0));
        step();
        rst = 1'b0;
        src_req = 4'b1111;
        step();
        check("t1_grant_after", 128'(src_grant), 128'(4'b0001));
        src_req = '0;
        d = mkdata(600, 0, 0);
        beat(0, d, 1'b1);
        check("t1_cnt_after", 128'(frame_cnt), 128'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
